commit_unit: RTL and testbench

//   In-order retirement stage directly downstream of the reorder buffer; consumes its head-entry commit bus.

---
 rtl/commit_unit_if.sv | 25 ++
 rtl/commit_unit.sv | 83 ++++++++
 tb/tb_commit_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/commit_unit_if.sv
// commit_unit_if: ROB head-entry commit bus. commit_op is 6 bits: NOP=0, ALU/imm ops 1..19, LUI=20, AUIPC=21,
// JAL=22, JALR=23, BEQ..BGEU=24..29, LB/LH/LW/LBU/LHU=30..34, SB=35, SH=36, SW=37.
interface commit_unit_if #(parameter int ROB_ID_W = 4, parameter int XLEN = 32);
  logic                commit_valid;
  logic [ROB_ID_W-1:0] commit_id;
  logic [5:0]          commit_op;
  logic [4:0]          commit_rd;
  logic [XLEN-1:0]     commit_value;
  logic [XLEN-1:0]     commit_pc;
  logic [XLEN-1:0]     commit_addr;
  logic                commit_pred;
  logic                commit_outcome;
  logic [XLEN-1:0]     commit_pred_target;
  logic                commit_ack;
  modport master (
    output commit_valid, commit_id, commit_op, commit_rd, commit_value, commit_pc,
           commit_addr, commit_pred, commit_outcome, commit_pred_target,
    input  commit_ack
  );
  modport slave (
    input  commit_valid, commit_id, commit_op, commit_rd, commit_value, commit_pc,
           commit_addr, commit_pred, commit_outcome, commit_pred_target,
    output commit_ack
  );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retire stage (regfile write, store handshake, mispredict flush).
// Define COMMIT_STATS_EN to add the retire and flush counters.
module commit_unit #(
  parameter int ROB_ID_W = 4,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  commit_unit_if.slave        cb,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [ROB_ID_W-1:0] rf_rob_id,
  output logic                st_req,
  output logic [XLEN-1:0]     st_addr,
  output logic [XLEN-1:0]     st_data,
  output logic [1:0]          st_size,
  input  logic                st_done,
  output logic                flush,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [31:0]         cnt_commit,
  output logic [31:0]         cnt_flush
);
  localparam logic [5:0] OP_NOP = 6'd0, OP_JAL = 6'd22, OP_JALR = 6'd23, OP_BEQ = 6'd24,
                         OP_BGEU = 6'd29, OP_SB = 6'd35, OP_SH = 6'd36, OP_SW = 6'd37;
  typedef enum logic [1:0] {IDLE, STORE_WAIT, FLUSH} state_t;
  state_t state, state_nx;
  logic is_st, is_br, is_jmp, wr_rd, mis_br, mis_jmp, idle_v, mis;
  always_comb begin
    is_st = cb.commit_op >= OP_SB && cb.commit_op <= OP_SW;
    is_br = cb.commit_op >= OP_BEQ && cb.commit_op <= OP_BGEU;
    is_jmp = cb.commit_op == OP_JAL || cb.commit_op == OP_JALR;
    wr_rd = cb.commit_op != OP_NOP && !is_br && !is_st && cb.commit_rd != 5'd0;
    mis_br = cb.commit_pred != cb.commit_outcome ||
             (cb.commit_outcome && cb.commit_pred_target != cb.commit_addr);
    mis_jmp = !cb.commit_pred || cb.commit_pred_target != cb.commit_addr;
    idle_v = state == IDLE && cb.commit_valid;
    mis = idle_v && (is_br ? mis_br : is_jmp && mis_jmp);
    cb.commit_ack = state == STORE_WAIT ? cb.commit_valid && st_done : idle_v && !is_st && !mis;
    // A non-store head in IDLE either acks or mispredicts; both write rd.
    rf_we = idle_v && !is_st && wr_rd;
    rf_waddr = rf_we ? cb.commit_rd : 5'd0;
    rf_wdata = rf_we ? cb.commit_value : '0;
    rf_rob_id = rf_we ? cb.commit_id : '0;
    state_nx = state == FLUSH ? IDLE :
               state == STORE_WAIT ? (st_done ? IDLE : STORE_WAIT) :
               idle_v && is_st ? STORE_WAIT : mis ? FLUSH : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_req <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
      st_size <= 2'd0;
      flush <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mis;
      if (idle_v && is_st) begin
        st_req <= 1'b1;
        st_addr <= cb.commit_addr;
        st_data <= cb.commit_value;
        st_size <= 2'(cb.commit_op - OP_SB);
      end else if (state == STORE_WAIT && st_done) st_req <= 1'b0;
      if (mis) redirect_pc <= is_jmp || cb.commit_outcome ? cb.commit_addr : cb.commit_pc + XLEN'(4);
    end
`ifdef COMMIT_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_commit <= '0;
      cnt_flush <= '0;
    end else begin
      cnt_commit <= cnt_commit + 32'(cb.commit_ack);
      cnt_flush <= cnt_flush + 32'(flush);
    end
`else
  assign cnt_commit = '0;
  assign cnt_flush = '0;
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed spec scenarios followed by random ROB-head traffic against a transaction model.
module tb_commit_unit;
  localparam int XLEN = 32, RW = 4;
  localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, ADDI = 6'd11, JAL = 6'd22, JALR = 6'd23,
                         BEQ = 6'd24, BGEU = 6'd29, SB = 6'd35, SH = 6'd36, SW = 6'd37;
  typedef struct {
    logic [5:0] op; logic [4:0] rd; logic [RW-1:0] id;
    logic [31:0] value, pc, addr, tgt; logic pred, outcome;
  } ins_t;
  logic clk = 1'b0, rst = 1'b0;
  logic rf_we, st_req, st_done, flush;
  logic [4:0] rf_waddr;
  logic [RW-1:0] rf_rob_id;
  logic [1:0] st_size;
  logic [XLEN-1:0] rf_wdata, st_addr, st_data, redirect_pc;
  logic [31:0] cnt_commit, cnt_flush;
  int total = 0, bad = 0, n_ack = 0, n_flush = 0;
  always #5 clk = ~clk;
  commit_unit_if #(.ROB_ID_W(RW), .XLEN(XLEN)) bus ();
  commit_unit #(.ROB_ID_W(RW), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .cb(bus.slave), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rob_id(rf_rob_id), .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_done(st_done), .flush(flush), .redirect_pc(redirect_pc), .cnt_commit(cnt_commit),
    .cnt_flush(cnt_flush)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_cnt();
`ifdef COMMIT_STATS_EN
    chk("cnt_commit", cnt_commit, n_ack);
    chk("cnt_flush", cnt_flush, n_flush);
`else
    chk("cnt_commit_tied", cnt_commit, 0);
    chk("cnt_flush_tied", cnt_flush, 0);
`endif
  endtask
  function automatic ins_t mk(logic [5:0] op, logic [4:0] rd, logic [31:0] value, logic [31:0] pc,
                              logic [31:0] addr, logic [31:0] tgt, logic pred, logic outcome);
    ins_t i;
    i.op = op; i.rd = rd; i.id = RW'($urandom); i.value = value; i.pc = pc;
    i.addr = addr; i.tgt = tgt; i.pred = pred; i.outcome = outcome;
    return i;
  endfunction
  function automatic ins_t rnd();
    logic [31:0] a = $urandom;
    return mk(6'($urandom_range(0, 37)), 5'($urandom), $urandom,
              $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : $urandom & ~32'd3, a,
              $urandom_range(0, 2) == 0 ? $urandom : a, 1'($urandom), 1'($urandom));
  endfunction
  task automatic drive(ins_t i, logic v);
    bus.commit_valid = v; bus.commit_op = i.op; bus.commit_rd = i.rd; bus.commit_id = i.id;
    bus.commit_value = i.value; bus.commit_pc = i.pc; bus.commit_addr = i.addr;
    bus.commit_pred_target = i.tgt; bus.commit_pred = i.pred; bus.commit_outcome = i.outcome;
  endtask
  task automatic idle_cycle();
    bus.commit_valid = 1'b0;
    st_done = 1'($urandom);
    @(negedge clk);
    chk("idle_ack", bus.commit_ack, 0);
    chk("idle_rf_we", rf_we, 0);
    @(posedge clk); #1;
  endtask
  // Present one ROB head and follow it until it retires or its flush completes.
  task automatic retire(ins_t i, int w);
    bit st, br, jmp, wr, mp;
    logic [31:0] rpc;
    st = i.op inside {SB, SH, SW};
    br = i.op >= BEQ && i.op <= BGEU;
    jmp = i.op == JAL || i.op == JALR;
    wr = i.op != NOP && !br && !st && i.rd != 0;
    if (br) mp = i.pred != i.outcome || (i.outcome && i.tgt != i.addr);
    else if (jmp) mp = !i.pred || i.tgt != i.addr;
    else mp = 0;
    rpc = (jmp || i.outcome) ? i.addr : i.pc + 32'd4;
    drive(i, 1'b1);
    st_done = st ? 1'b0 : 1'($urandom);
    @(negedge clk);
    chk("st_req_idle", st_req, 0);
    chk("flush_idle", flush, 0);
    chk("ack", bus.commit_ack, !st && !mp);
    chk("rf_we", rf_we, wr);
    if (wr) begin
      chk("rf_waddr", rf_waddr, i.rd);
      chk("rf_wdata", rf_wdata, i.value);
      chk("rf_rob_id", rf_rob_id, i.id);
    end
    if (!st && !mp) n_ack++;
    @(posedge clk); #1;
    if (st) begin
      for (int k = 0; k < w; k++) begin
        @(negedge clk);
        chk("st_hold", st_req, 1);
        chk("st_ack_early", bus.commit_ack, 0);
        @(posedge clk); #1;
      end
      st_done = 1'b1;
      @(negedge clk);
      chk("st_req", st_req, 1);
      chk("st_addr", st_addr, i.addr);
      chk("st_data", st_data, i.value);
      chk("st_size", st_size, i.op == SB ? 0 : i.op == SH ? 1 : 2);
      chk("st_ack", bus.commit_ack, 1);
      chk("st_rf_we", rf_we, 0);
      n_ack++;
      @(posedge clk); #1;
      st_done = 1'b0;
    end else if (mp) begin
      drive(rnd(), 1'($urandom));
      st_done = 1'($urandom);
      @(negedge clk);
      chk("flush", flush, 1);
      chk("redirect_pc", redirect_pc, rpc);
      chk("flush_ack", bus.commit_ack, 0);
      chk("flush_rf_we", rf_we, 0);
      chk("flush_st_req", st_req, 0);
      n_flush++;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    drive(mk(NOP, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    st_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_st_req", st_req, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_st_addr", st_addr, 0);
    chk_cnt();
    rst = 1'b1;
    @(posedge clk); #1;
    retire(mk(ADD, 5, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 0), 0);
    chk_cnt();
    retire(mk(ADDI, 0, 32'h55, 32'h4, 32'h0, 32'h0, 0, 0), 0);
    retire(mk(SW, 0, 32'hDEAD_BEEF, 32'h8, 32'h100, 32'h0, 0, 0), 3);
    retire(mk(BEQ, 0, 32'h0, 32'h40, 32'h200, 32'h200, 1, 0), 0);
    chk_cnt();
    retire(mk(JALR, 1, 32'h20, 32'h60, 32'h80, 32'h84, 1, 1), 0);
    retire(mk(JAL, 3, 32'h94, 32'h90, 32'h300, 32'h300, 1, 1), 0);
    retire(mk(BEQ, 0, 32'h0, 32'hFFFF_FFFC, 32'h10, 32'h10, 0, 1), 0);
    retire(mk(BGEU, 0, 32'h0, 32'h50, 32'h10, 32'h14, 1, 1), 0);
    chk_cnt();
    drive(mk(SH, 0, 32'hCAFE, 32'h70, 32'h400, 32'h0, 0, 0), 1'b1);
    st_done = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_st_req", st_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_st_req", st_req, 0);
    chk("async_rst_flush", flush, 0);
    chk("async_rst_ack", bus.commit_ack, 0);
    bus.commit_valid = 1'b0;
    n_ack = 0;
    n_flush = 0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt();
    rst = 1'b1;
    @(posedge clk); #1;
    retire(mk(ADD, 7, 32'h77, 32'h0, 32'h0, 32'h0, 0, 0), 0);
    chk_cnt();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) idle_cycle();
      retire(rnd(), $urandom_range(0, 4));
    end
    idle_cycle();
    chk_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
